// File: rtl/tri_side_loader.sv
// Serial side loader and result register for the combinational right-triangle checker.
// Holds three sides stable for one evaluation cycle, then presents ret/area downstream.
module tri_side_loader #(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_side,
  output logic [N-1:0]       tri_a,
  output logic [N-1:0]       tri_b,
  output logic [N-1:0]       tri_c,
  input  logic [2*N-2:0]     tri_area,
  input  logic               tri_ret,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_ret,
  output logic [2*N-2:0]     out_area,
  output logic [CNT_W-1:0]   cnt_total,
  output logic [CNT_W-1:0]   cnt_right
);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_C = 3'd2,
    EVAL   = 3'd3,
    OUT    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t             state_q, state_d;
  logic [N-1:0]       tri_a_q, tri_a_d;
  logic [N-1:0]       tri_b_q, tri_b_d;
  logic [N-1:0]       tri_c_q, tri_c_d;
  logic [2*N-2:0]     out_area_q, out_area_d;
  logic               out_ret_q, out_ret_d;
  logic [CNT_W-1:0]   cnt_total_q, cnt_total_d;
  logic [CNT_W-1:0]   cnt_right_q, cnt_right_d;
  logic               zero_flag;
  logic               ret_cap;

  // A zero side satisfies a^2+b^2=c^2 trivially but is not a triangle.
  assign zero_flag = (tri_a_q == '0) | (tri_b_q == '0) | (tri_c_q == '0);
  assign ret_cap   = tri_ret & ~zero_flag;

  always_comb begin
    state_d     = state_q;
    tri_a_d     = tri_a_q;
    tri_b_d     = tri_b_q;
    tri_c_d     = tri_c_q;
    out_area_d  = out_area_q;
    out_ret_d   = out_ret_q;
    cnt_total_d = cnt_total_q;
    cnt_right_d = cnt_right_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tri_a_d = in_side;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tri_b_d = in_side;
          state_d = LOAD_C;
        end
      end
      LOAD_C: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tri_c_d = in_side;
          state_d = EVAL;
        end
      end
      EVAL: begin
        out_area_d  = tri_area;
        out_ret_d   = ret_cap;
        cnt_total_d = sat_inc(cnt_total_q);
        if (ret_cap) cnt_right_d = sat_inc(cnt_right_q);
        state_d     = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  // Single register stage: FSM, held sides, captured result and statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LOAD_A;
      tri_a_q     <= '0;
      tri_b_q     <= '0;
      tri_c_q     <= '0;
      out_area_q  <= '0;
      out_ret_q   <= 1'b0;
      cnt_total_q <= '0;
      cnt_right_q <= '0;
    end else begin
      state_q     <= state_d;
      tri_a_q     <= tri_a_d;
      tri_b_q     <= tri_b_d;
      tri_c_q     <= tri_c_d;
      out_area_q  <= out_area_d;
      out_ret_q   <= out_ret_d;
      cnt_total_q <= cnt_total_d;
      cnt_right_q <= cnt_right_d;
    end
  end

  assign tri_a     = tri_a_q;
  assign tri_b     = tri_b_q;
  assign tri_c     = tri_c_q;
  assign out_area  = out_area_q;
  assign out_ret   = out_ret_q;
  assign cnt_total = cnt_total_q;
  assign cnt_right = cnt_right_q;

endmodule

// File: tb/tb_tri_side_loader.sv
// Directed bench for tri_side_loader with a behavioural right-triangle checker and result scoreboard.
module tb_tri_side_loader;

  localparam int N     = 16;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_side;
  logic [N-1:0]       tri_a, tri_b, tri_c;
  logic [2*N-2:0]     tri_area;
  logic               tri_ret;
  logic               out_valid;
  logic               out_ready;
  logic               out_ret;
  logic [2*N-2:0]     out_area;
  logic [CNT_W-1:0]   cnt_total, cnt_right;

  tri_side_loader #(.N(N), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_side   (in_side),
    .tri_a     (tri_a),
    .tri_b     (tri_b),
    .tri_c     (tri_c),
    .tri_area  (tri_area),
    .tri_ret   (tri_ret),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ret   (out_ret),
    .out_area  (out_area),
    .cnt_total (cnt_total),
    .cnt_right (cnt_right)
  );

  always #5 clock = ~clock;

  // Behavioural stand-in for the combinational checker.
  function automatic logic chk_right(input longint a, input longint b, input longint c);
    longint h, x, y;
    if (a >= b && a >= c) begin h = a; x = b; y = c; end
    else if (b >= c)      begin h = b; x = a; y = c; end
    else                  begin h = c; x = a; y = b; end
    return (x * x + y * y) == (h * h);
  endfunction

  function automatic logic [2*N-2:0] chk_area(input longint a, input longint b, input longint c);
    longint h, x, y, ar;
    if (a >= b && a >= c) begin h = a; x = b; y = c; end
    else if (b >= c)      begin h = b; x = a; y = c; end
    else                  begin h = c; x = a; y = b; end
    ar = ((x * x + y * y) == (h * h)) ? (x * y) / 2 : 0;
    return ar[2*N-2:0];
  endfunction

  always_comb begin
    tri_ret  = chk_right(longint'(tri_a), longint'(tri_b), longint'(tri_c));
    tri_area = chk_area(longint'(tri_a), longint'(tri_b), longint'(tri_c));
  end

  typedef struct {
    logic [N-1:0]     a, b, c;
    logic             ret;
    logic [2*N-2:0]   area;
    logic [CNT_W-1:0] tot, rgt;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_tot  = 0;
  int   exp_rgt  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_side(input logic [N-1:0] s);
    in_valid = 1'b1;
    in_side  = s;
    for (int k = 0; k < 20 && !in_ready; k++) begin
      @(posedge clock); #1;
    end
    chk("in_ready_load", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_triple(input int a, input int b, input int c);
    exp_t e;
    logic r;
    r = chk_right(a, b, c) && a != 0 && b != 0 && c != 0;
    exp_tot = (exp_tot < CNT_MAX) ? exp_tot + 1 : CNT_MAX;
    if (r) exp_rgt = (exp_rgt < CNT_MAX) ? exp_rgt + 1 : CNT_MAX;
    e.a = N'(a); e.b = N'(b); e.c = N'(c);
    e.ret  = r;
    e.area = chk_area(a, b, c);
    e.tot  = CNT_W'(exp_tot);
    e.rgt  = CNT_W'(exp_rgt);
    sb.push_back(e);
    send_side(N'(a));
    send_side(N'(b));
    send_side(N'(c));
    chk("eval_out_valid", out_valid, 1'b0);
    chk("eval_in_ready", in_ready, 1'b0);
  endtask

  task automatic get_result(input int hold);
    exp_t e;
    @(posedge clock); #1;
    chk("out_valid_rise", out_valid, 1'b1);
    chk("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("tri_a", tri_a, e.a);
    chk("tri_b", tri_b, e.b);
    chk("tri_c", tri_c, e.c);
    chk("out_ret", out_ret, e.ret);
    chk("out_area", out_area, e.area);
    chk("cnt_total", cnt_total, e.tot);
    chk("cnt_right", cnt_right, e.rgt);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_side  = N'(77);
      @(posedge clock); #1;
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_out_ret", out_ret, e.ret);
      chk("hold_out_area", out_area, e.area);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_tri_a", tri_a, e.a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("consumed_out_valid", out_valid, 1'b0);
    chk("consumed_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_side = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_tri_a", tri_a, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt_total", cnt_total, 0);
    reset = 1'b0;

    send_triple(3, 4, 5);   get_result(0);
    send_triple(13, 5, 12); get_result(0);
    send_triple(2, 3, 4);   get_result(0);
    send_triple(0, 7, 7);   get_result(0);
    send_triple(6, 8, 10);  get_result(5);

    // Partial triple abandoned by a reset that coincides with a valid side.
    send_side(N'(3));
    send_side(N'(4));
    reset = 1'b1; in_valid = 1'b1; in_side = N'(99); out_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_tot = 0; exp_rgt = 0;
    chk("mid_rst_tri_a", tri_a, 0);
    chk("mid_rst_tri_b", tri_b, 0);
    chk("mid_rst_tri_c", tri_c, 0);
    chk("mid_rst_out_ret", out_ret, 0);
    chk("mid_rst_out_area", out_area, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_cnt_total", cnt_total, 0);
    chk("mid_rst_cnt_right", cnt_right, 0);
    send_triple(5, 12, 13); get_result(0);

    // Drive both counters into saturation.
    send_triple(2, 3, 4); get_result(0);
    for (int i = 0; i < 7; i++) begin
      send_triple(3, 4, 5); get_result(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
